// File: rtl/mux_scan_ctrl.sv
// Round-robin sequencer for an 8:1 channel mux.
// Selects, dwells, captures and hands off samples over valid/ready.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         EN,
    input  logic [7:0]   MASK,
    input  logic [W-1:0] D,
    input  logic         READY,
    output logic [2:0]   S,
    output logic [W-1:0] Q,
    output logic [2:0]   QCH,
    output logic         VALID,
    output logic         FRAME
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_OUT
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    logic [2:0] lowest;
    logic [2:0] above;
    logic       found_above;
    logic [2:0] next_ch;
    logic       wrap;

    // Lowest enabled channel overall and lowest enabled channel above S.
    always_comb begin
        lowest      = 3'd0;
        above       = 3'd0;
        found_above = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (MASK[i]) begin
                lowest = i[2:0];
                if (i[2:0] > S) begin
                    above       = i[2:0];
                    found_above = 1'b1;
                end
            end
        end
        next_ch = found_above ? above : lowest;
        wrap    = (MASK != 8'd0) && !found_above;
    end

    // Frame marks the handshake that closes a scan pass.
    assign FRAME = (state == ST_OUT) && READY && wrap;

    // Scan state machine: select, dwell, capture, hand off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            S     <= 3'd0;
            Q     <= '0;
            QCH   <= 3'd0;
            VALID <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (EN && (MASK != 8'd0)) begin
                        S     <= lowest;
                        cnt   <= 4'd0;
                        state <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (!EN) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'(DWELL - 1)) begin
                        Q     <= D;
                        QCH   <= S;
                        VALID <= 1'b1;
                        state <= ST_OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (READY) begin
                        VALID <= 1'b0;
                        if (!EN || (MASK == 8'd0)) begin
                            state <= ST_IDLE;
                        end else begin
                            S     <= next_ch;
                            cnt   <= 4'd0;
                            state <= ST_DWELL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl.
// Transaction-level channel model with randomized data and backpressure.
module tb_mux_scan_ctrl;

    localparam int DW = 4;
    localparam int WD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          EN;
    logic [7:0]    MASK;
    logic [WD-1:0] D;
    logic          READY;
    logic [2:0]    S;
    logic [WD-1:0] Q;
    logic [2:0]    QCH;
    logic          VALID;
    logic          FRAME;

    logic [WD-1:0] mux_in [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign D = mux_in[S];

    mux_scan_ctrl #(.DWELL(DW), .W(WD)) dut (
        .clk(clk), .rst(rst), .EN(EN), .MASK(MASK), .D(D),
        .READY(READY), .S(S), .Q(Q), .QCH(QCH),
        .VALID(VALID), .FRAME(FRAME)
    );

    // Next enabled channel after cur, scanning cyclically.
    function automatic int exp_next(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (cur + k) % 8;
            if (m[c]) return c;
        end
        return cur;
    endfunction

    task automatic do_reset();
        rst = 1'b1; EN = 1'b0; READY = 1'b0; MASK = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1; EN = 1'b0; READY = 1'b0; MASK = 8'd0;
        for (int i = 0; i < 8; i++) mux_in[i] = WD'(i + 1);
        #2;
        checks++;
        if ({S, Q, QCH, VALID, FRAME} !== 12'd0) begin
            errors++;
            $display("FAIL reset_init: got %h want 0",
                     {S, Q, QCH, VALID, FRAME});
        end
        @(negedge clk);
        rst = 1'b0; MASK = 8'h20; EN = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({S, Q, QCH, VALID, FRAME} !== 12'd0) begin
            errors++;
            $display("FAIL reset_dwell: got %h want 0",
                     {S, Q, QCH, VALID, FRAME});
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (!VALID && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (QCH !== 3'd5 || Q !== WD'(6) || VALID !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_out: qch=%0d q=%0d v=%0b want 5 6 1",
                     QCH, Q, VALID);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({S, Q, QCH, VALID, FRAME} !== 12'd0) begin
            errors++;
            $display("FAIL reset_out: got %h want 0",
                     {S, Q, QCH, VALID, FRAME});
        end
        @(negedge clk);
        EN = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (VALID !== 1'b0 || S !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle_hold: v=%0b s=%0d want 0 0",
                         VALID, S);
            end
        end
    endtask

    task automatic test_scan(input string nm, input logic [7:0] m,
                             input int n, input bit rnd);
        int exp_ch, nx, cyc, hold;
        bit got;
        logic [WD-1:0] hq;
        logic [2:0] hc, hs;
        do_reset();
        MASK = m;
        READY = rnd ? 1'($urandom % 2) : 1'b1;
        EN = 1'b1;
        exp_ch = exp_next(m, 7);
        for (int s = 0; s < n; s++) begin
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 50) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (cyc == 1) begin
                    checks++;
                    if (S !== 3'(exp_ch) || VALID !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_select: s=%0d v=%0b want %0d 0",
                                 nm, S, VALID, exp_ch);
                    end
                end
                if (VALID) got = 1'b1;
                else if (rnd) READY = 1'($urandom % 2);
            end
            if (!got) begin
                errors++;
                checks++;
                $display("FAIL %s_timeout: no VALID after %0d cycles",
                         nm, cyc);
                return;
            end
            checks++;
            if (cyc != DW + 1) begin
                errors++;
                $display("FAIL %s_latency: got %0d want %0d",
                         nm, cyc, DW + 1);
            end
            checks++;
            if (QCH !== 3'(exp_ch) || Q !== mux_in[exp_ch]) begin
                errors++;
                $display("FAIL %s_sample: qch=%0d q=%0d want %0d %0d",
                         nm, QCH, Q, exp_ch, mux_in[exp_ch]);
            end
            if (rnd) begin
                READY = 1'b0;
                hq = Q; hc = QCH; hs = S;
                hold = $urandom_range(0, 3);
                repeat (hold) begin
                    @(negedge clk);
                    checks++;
                    if (VALID !== 1'b1 || Q !== hq || QCH !== hc ||
                        S !== hs || FRAME !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_hold: v=%0b q=%0d qch=%0d s=%0d",
                                 nm, VALID, Q, QCH, S);
                    end
                end
            end
            READY = 1'b1;
            nx = exp_next(m, exp_ch);
            #1;
            checks++;
            if (FRAME !== (nx <= exp_ch)) begin
                errors++;
                $display("FAIL %s_frame: ch=%0d got %0b want %0b",
                         nm, exp_ch, FRAME, (nx <= exp_ch));
            end
            exp_ch = nx;
        end
        EN = 1'b0;
        READY = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [WD-1:0] hq;
        logic [2:0] hc;
        do_reset();
        for (int i = 0; i < 8; i++) mux_in[i] = WD'($urandom);
        MASK = 8'h11;
        EN = 1'b1;
        cyc = 0;
        while (!VALID && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (VALID !== 1'b1 || QCH !== 3'd0 || Q !== mux_in[0]) begin
            errors++;
            $display("FAIL bp_first: v=%0b qch=%0d q=%0d want 1 0 %0d",
                     VALID, QCH, Q, mux_in[0]);
        end
        hq = Q; hc = QCH;
        repeat (10) begin
            @(negedge clk);
            mux_in[0] = WD'($urandom);
            checks++;
            if (VALID !== 1'b1 || Q !== hq || QCH !== hc || S !== 3'd0) begin
                errors++;
                $display("FAIL bp_stable: v=%0b q=%0d qch=%0d s=%0d",
                         VALID, Q, QCH, S);
            end
        end
        READY = 1'b1;
        @(posedge clk);
        #1 READY = 1'b0;
        checks++;
        if (VALID !== 1'b0 || S !== 3'd4) begin
            errors++;
            $display("FAIL bp_release: v=%0b s=%0d want 0 4", VALID, S);
        end
        EN = 1'b0;
    endtask

    task automatic test_en_mask_edges();
        int cyc;
        do_reset();
        MASK = 8'h0C;
        EN = 1'b1;
        repeat (2) @(negedge clk);
        EN = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (VALID !== 1'b0 || S !== 3'd2 || FRAME !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_dwell: v=%0b s=%0d f=%0b",
                         VALID, S, FRAME);
            end
        end
        EN = 1'b1;
        cyc = 0;
        while (!VALID && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (VALID !== 1'b1 || QCH !== 3'd2) begin
            errors++;
            $display("FAIL mask_zero_pre: v=%0b qch=%0d want 1 2",
                     VALID, QCH);
        end
        MASK = 8'h00;
        READY = 1'b1;
        @(negedge clk);
        READY = 1'b0;
        repeat (6) begin
            checks++;
            if (VALID !== 1'b0 || S !== 3'd2) begin
                errors++;
                $display("FAIL mask_zero_idle: v=%0b s=%0d want 0 2",
                         VALID, S);
            end
            @(negedge clk);
        end
        MASK = 8'h0C;
        cyc = 0;
        while (!VALID && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (VALID !== 1'b1 || QCH !== 3'd2) begin
            errors++;
            $display("FAIL en_out_pre: v=%0b qch=%0d want 1 2", VALID, QCH);
        end
        EN = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (VALID !== 1'b1) begin
                errors++;
                $display("FAIL en_out_hold: v=%0b want 1", VALID);
            end
        end
        READY = 1'b1;
        @(negedge clk);
        READY = 1'b0;
        repeat (6) begin
            checks++;
            if (VALID !== 1'b0 || S !== 3'd2) begin
                errors++;
                $display("FAIL en_out_idle: v=%0b s=%0d want 0 2", VALID, S);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 8; i++) mux_in[i] = WD'(i + 1);
        test_scan("full", 8'hFF, 9, 1'b0);
        for (int i = 0; i < 8; i++) mux_in[i] = WD'($urandom);
        test_scan("sparse", 8'b1010_0100, 7, 1'b0);
        test_scan("single", 8'h08, 4, 1'b0);
        test_backpressure();
        for (int t = 0; t < 4; t++) begin
            logic [7:0] m;
            m = 8'($urandom);
            if (m == 8'd0) m = 8'h81;
            for (int i = 0; i < 8; i++) mux_in[i] = WD'($urandom);
            test_scan("rand", m, 10, 1'b1);
        end
        test_en_mask_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
